// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read arbiter: ROM geometry, FSM state
// encoding, and a helper for sizing client index fields.
package rom_pkg;

   localparam int ROM_ADDR_W = 3;
   localparam int ROM_DATA_W = 16;
   localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // A single client still needs a 1-bit index field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search begins one past the previous winner and wraps around.
module rr_arbiter
   import rom_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any
);

   int w_idx;

   always_comb begin
      // NOTE: every output gets a default before the search loop, so no path leaves a latch.
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_idx       = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_idx = (int'(i_last_grant) + off) % NUM_REQ;
         if (!o_any && i_req[w_idx]) begin
            o_any          = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output synchronous ROM among NUM_REQ read clients.
// Requests are granted round-robin, and only one ROM access is outstanding at a time.
module rom_read_arbiter
   import rom_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ROM_ADDR_W,
   parameter int DATA_W  = ROM_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic                      rom_en,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data
);

   localparam int                 IDX_W     = idx_width(NUM_REQ);
   localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

   state_t               r_state;
   logic [IDX_W-1:0]     r_last_grant;
   logic [IDX_W-1:0]     r_grant_idx;
   logic                 r_rom_en;
   logic [ADDR_W-1:0]    r_rom_addr;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [DATA_W-1:0]    r_rsp_data;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_grant_idx;
   logic                 w_any;
   logic [ADDR_W-1:0]    w_sel_addr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx),
      .o_any        (w_any)
   );

   always_comb begin
      w_sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_idx == IDX_W'(i)) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Gating with rst_n keeps req_ready low while reset is held, even though the FSM is in IDLE.
   assign req_ready = (r_state == S_IDLE && rst_n) ? w_grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= LAST_INIT;
         r_grant_idx  <= '0;
         r_rom_en     <= 1'b0;
         r_rom_addr   <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
      end else begin
         // NOTE: state and registered outputs all use <=, so each branch reads pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant_idx <= w_grant_idx;
                  r_rom_en    <= 1'b1;
                  r_rom_addr  <= w_sel_addr;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_rom_en   <= 1'b0;
               r_rom_addr <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // rom_data is captured only here, so undriven values in other states never reach rsp_data.
               r_rsp_data  <= rom_data;
               r_rsp_valid <= ONE_HOT0 << r_grant_idx;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready[r_grant_idx]) begin
                  r_rsp_valid  <= '0;
                  r_last_grant <= r_grant_idx;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rom_en    = r_rom_en;
   assign rom_addr  = r_rom_addr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one 8x16 synchronous ROM (registered output, 1-cycle read latency, enable-gated) between NUM_REQ independent read clients.
- Round-robin grant, valid/ready handshake on request and response, one outstanding ROM access at a time.
- Sits between the ROM instance and the client blocks. It is the only agent that drives the ROM's en/addr.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..4).
- ADDR_W, 3, ROM address width.
- DATA_W, 16, ROM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  client i requests a read.
- req_addr  in  NUM_REQ*ADDR_W  client i address, slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot; request i accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot; read data for client i is on rsp_data.
- rsp_data  out  DATA_W  read data, shared by all clients.
- rsp_ready  in  NUM_REQ  client i consumes its response.
- rom_en  out  1  ROM enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM registered output. High-Z/X when the ROM is not enabled.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous assert, active-low; release is synchronous to clk.
- FSM states:
  - IDLE: if any req_valid, pick grant g by round-robin, assert req_ready[g] combinationally, latch req_addr[g] and g, go to ISSUE. Otherwise stay.
  - ISSUE: rom_en=1, rom_addr=latched address, go to WAIT.
  - WAIT: rom_en=0. rom_data is valid this cycle; register it into rsp_data. Set rsp_valid[g]=1. Go to RESP.
  - RESP: hold rsp_valid[g] and rsp_data stable until rsp_ready[g]=1. On that cycle clear rsp_valid, set last_grant=g, go to IDLE.
- Round-robin:
  - Priority search starts at (last_grant+1) mod NUM_REQ.
  - After reset last_grant=NUM_REQ-1, so client 0 wins the first contest.
  - last_grant updates only on response handshake.
- req_ready is high only in IDLE and only for g. At most one bit is set. req_ready never asserts in the cycle rsp handshake completes (that cycle is in RESP).
- rom_en is high exactly one cycle per accepted request; rom_addr=0 when rom_en=0.
- rom_data is sampled only in WAIT. Z/X on rom_data in any other state must not propagate to rsp_data.
- Latency: handshake in cycle N gives rom_en in N+1 and rsp_valid high from N+3.
  - With rsp_ready tied high, the next accept is at N+4, so minimum 4 cycles/read.
- rsp_ready on a non-granted client, or while rsp_valid is low, is ignored.
- A client may drop req_valid before it is granted, with no effect. req_addr is only sampled at accept.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rom_en=0, rom_addr=0, state=IDLE, last_grant=NUM_REQ-1.
- Reset mid-operation (any state): outstanding access is abandoned, no response is delivered, and all outputs take their reset values immediately.
- Address wrap: the full 0..2^ADDR_W-1 range is legal. There is no out-of-range case.

Decomposition:
- Shared package rom_pkg: ROM_ADDR_W=3, ROM_DATA_W=16, FSM state enum (IDLE, ISSUE, WAIT, RESP), 2-bit encoding.
- One sub-module: rr_arbiter (request vector + last_grant in, one-hot grant + index out; combinational priority rotate).

Test Plan:
- Reset then single request: client0 addr=3, rsp_ready=1 -> req_ready[0] same cycle, rom_en one cycle later with rom_addr=3, rsp_valid[0] at +3 with rsp_data=16'hcd21.
- Simultaneous request after reset: client0 addr=0, client1 addr=7, both held -> client0 served first (16'habcd), then client1 (16'ha525), then client0 again. Grants strictly alternate over 6 reads.
- Response backpressure: client1 addr=5, rsp_ready low 5 cycles -> rsp_valid[1] and rsp_data=16'h7a3d held stable, no new req_ready, rom_en low throughout; release -> IDLE next cycle.
- Reset mid-operation: assert rst_n low during WAIT -> rsp_valid stays 0, rom_en 0 immediately; after release client0 addr=1 returns 16'h23cd normally.
- Sweep: client0 reads addr 0..7 back-to-back with rsp_ready=1 -> abcd,23cd,98cd,cd21,9bc7,7a3d,7430,a525 at a 4-cycle spacing, no X on rsp_data.
- Idle hygiene: no req_valid for 20 cycles -> rom_en=0, rom_addr=0, rsp_valid=0 throughout.
